// File: rtl/sgpr_busy_table_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sgpr_busy_table_pkg                                              |
// | Brief   : Shared constants, size codes and FSM encodings for the SGPR      |
// |           busy scoreboard.                                                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sgpr_busy_table_pkg;

  localparam int NUMBER_SGPR_DEF      = 512;
  localparam int SGPR_ADDR_LENGTH_DEF = 9;
  localparam int FLUSH_STRIDE_DEF     = 8;

  localparam logic [1:0] SIZE_1W  = 2'd0;
  localparam logic [1:0] SIZE_2W  = 2'd1;
  localparam logic [1:0] SIZE_4W  = 2'd2;
  localparam logic [1:0] SIZE_BAD = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Illegal size code maps to zero words so the port changes nothing.
  function automatic logic [2:0] size_to_words(input logic [1:0] size);
    logic [2:0] words;
    words = 3'd0;
    case (size)
      SIZE_1W: words = 3'd1;
      SIZE_2W: words = 3'd2;
      SIZE_4W: words = 3'd4;
      default: words = 3'd0;
    endcase
    return words;
  endfunction

endpackage : sgpr_busy_table_pkg
`default_nettype wire

// File: rtl/sgpr_busy_table_mask_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sgpr_range_mask_gen                                              |
// | Brief   : Builds a NUMBER_SGPR-bit mask of count_i entries from base_i,    |
// |           wrapping modulo the table depth.                                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sgpr_range_mask_gen #(
  parameter int NUMBER_SGPR = 512,
  parameter int ADDR_W      = 9,
  parameter int CNT_W       = 10
) (
  input  logic [ADDR_W-1:0]      base_i,
  input  logic [CNT_W-1:0]       count_i,
  output logic [NUMBER_SGPR-1:0] mask_o
);

  // Depth is a power of two, so the address subtraction wraps for free.
  for (genvar i = 0; i < NUMBER_SGPR; i++) begin : g_bit
    localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(i);
    logic [ADDR_W-1:0] offset;
    assign offset    = c_IDX - base_i;
    assign mask_o[i] = (CNT_W'(offset) < count_i);
  end

endmodule : sgpr_range_mask_gen
`default_nettype wire

// File: rtl/sgpr_busy_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sgpr_busy_table                                                  |
// | Brief   : Global scalar-GPR busy scoreboard with issue set, SALU/LSU       |
// |           writeback clears and a multi-cycle range flush.                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sgpr_busy_table
  import sgpr_busy_table_pkg::*;
#(
  parameter int NUMBER_SGPR      = NUMBER_SGPR_DEF,
  parameter int SGPR_ADDR_LENGTH = SGPR_ADDR_LENGTH_DEF,
  parameter int FLUSH_STRIDE     = FLUSH_STRIDE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_en,
  input  logic [SGPR_ADDR_LENGTH-1:0] set_addr,
  input  logic [1:0]                  set_size,
  input  logic                        salu_clr_en,
  input  logic [SGPR_ADDR_LENGTH-1:0] salu_clr_addr,
  input  logic [1:0]                  salu_clr_size,
  input  logic                        lsu_clr_en,
  input  logic [SGPR_ADDR_LENGTH-1:0] lsu_clr_addr,
  input  logic [1:0]                  lsu_clr_size,
  input  logic                        flush_req,
  input  logic [SGPR_ADDR_LENGTH-1:0] flush_base,
  input  logic [SGPR_ADDR_LENGTH:0]   flush_count,
  output logic                        flush_busy,
  output logic                        flush_ack,
  output logic [NUMBER_SGPR-1:0]      busy_table,
  output logic                        err_double_set,
  output logic                        err_clr_idle,
  output logic                        err_bad_size
);

  localparam int                CNT_W    = SGPR_ADDR_LENGTH + 1;
  localparam logic [CNT_W-1:0]  C_STRIDE = CNT_W'(FLUSH_STRIDE);

  logic [NUMBER_SGPR-1:0]      busy_q, busy_d;
  logic [NUMBER_SGPR-1:0]      set_mask, salu_mask, lsu_mask, flush_mask;
  logic [CNT_W-1:0]            set_cnt, salu_cnt, lsu_cnt, flush_cnt;
  logic [0:0]                  state_q, state_d;
  logic [SGPR_ADDR_LENGTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]            rem_q, rem_d;
  logic                        ack_q, ack_d;
  logic                        err_double_q, err_clr_q, err_size_q;
  logic                        bad_size_hit;

  assign set_cnt  = set_en      ? CNT_W'(size_to_words(set_size))      : '0;
  assign salu_cnt = salu_clr_en ? CNT_W'(size_to_words(salu_clr_size)) : '0;
  assign lsu_cnt  = lsu_clr_en  ? CNT_W'(size_to_words(lsu_clr_size))  : '0;

  sgpr_range_mask_gen #(.NUMBER_SGPR(NUMBER_SGPR), .ADDR_W(SGPR_ADDR_LENGTH), .CNT_W(CNT_W))
    u_set_mask   (.base_i(set_addr),      .count_i(set_cnt),   .mask_o(set_mask));
  sgpr_range_mask_gen #(.NUMBER_SGPR(NUMBER_SGPR), .ADDR_W(SGPR_ADDR_LENGTH), .CNT_W(CNT_W))
    u_salu_mask  (.base_i(salu_clr_addr), .count_i(salu_cnt),  .mask_o(salu_mask));
  sgpr_range_mask_gen #(.NUMBER_SGPR(NUMBER_SGPR), .ADDR_W(SGPR_ADDR_LENGTH), .CNT_W(CNT_W))
    u_lsu_mask   (.base_i(lsu_clr_addr),  .count_i(lsu_cnt),   .mask_o(lsu_mask));
  sgpr_range_mask_gen #(.NUMBER_SGPR(NUMBER_SGPR), .ADDR_W(SGPR_ADDR_LENGTH), .CNT_W(CNT_W))
    u_flush_mask (.base_i(ptr_q),         .count_i(flush_cnt), .mask_o(flush_mask));

  // Flush FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
    end
  end

  // Flush FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          if (flush_count == '0) begin
            ack_d = 1'b1;
          end else begin
            ptr_d   = flush_base;
            rem_d   = flush_count;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        ptr_d = ptr_q + SGPR_ADDR_LENGTH'(FLUSH_STRIDE);
        if (rem_q <= C_STRIDE) begin
          rem_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_q - C_STRIDE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flush FSM: outputs
  always_comb begin
    flush_busy = (state_q == ST_FLUSH);
    flush_cnt  = '0;
    if (state_q == ST_FLUSH) begin
      flush_cnt = (rem_q < C_STRIDE) ? rem_q : C_STRIDE;
    end
  end

  assign flush_ack = ack_q;

  // Set is OR-ed in last so it wins over any same-cycle clear or flush.
  assign busy_d = (busy_q & ~salu_mask & ~lsu_mask & ~flush_mask) | set_mask;

  assign bad_size_hit = (set_en      && (set_size      == SIZE_BAD)) ||
                        (salu_clr_en && (salu_clr_size == SIZE_BAD)) ||
                        (lsu_clr_en  && (lsu_clr_size  == SIZE_BAD));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      err_double_q <= 1'b0;
      err_clr_q    <= 1'b0;
      err_size_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      err_double_q <= err_double_q | (|(set_mask & busy_q));
      err_clr_q    <= err_clr_q | (|((salu_mask | lsu_mask) & ~busy_q));
      err_size_q   <= err_size_q | bad_size_hit;
    end
  end

  assign busy_table     = busy_q;
  assign err_double_set = err_double_q;
  assign err_clr_idle   = err_clr_q;
  assign err_bad_size   = err_size_q;

endmodule : sgpr_busy_table
`default_nettype wire

// File: tb/tb_sgpr_busy_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sgpr_busy_table                                               |
// | Brief   : Directed self-checking bench for the SGPR busy scoreboard.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sgpr_busy_table;

  localparam int N  = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          set_en;
  logic [AW-1:0] set_addr;
  logic [1:0]    set_size;
  logic          salu_clr_en;
  logic [AW-1:0] salu_clr_addr;
  logic [1:0]    salu_clr_size;
  logic          lsu_clr_en;
  logic [AW-1:0] lsu_clr_addr;
  logic [1:0]    lsu_clr_size;
  logic          flush_req;
  logic [AW-1:0] flush_base;
  logic [AW:0]   flush_count;
  logic          flush_busy;
  logic          flush_ack;
  logic [N-1:0]  busy_table;
  logic          err_double_set;
  logic          err_clr_idle;
  logic          err_bad_size;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sgpr_busy_table dut (
    .clk           (clk),
    .rst           (rst),
    .set_en        (set_en),
    .set_addr      (set_addr),
    .set_size      (set_size),
    .salu_clr_en   (salu_clr_en),
    .salu_clr_addr (salu_clr_addr),
    .salu_clr_size (salu_clr_size),
    .lsu_clr_en    (lsu_clr_en),
    .lsu_clr_addr  (lsu_clr_addr),
    .lsu_clr_size  (lsu_clr_size),
    .flush_req     (flush_req),
    .flush_base    (flush_base),
    .flush_count   (flush_count),
    .flush_busy    (flush_busy),
    .flush_ack     (flush_ack),
    .busy_table    (busy_table),
    .err_double_set(err_double_set),
    .err_clr_idle  (err_clr_idle),
    .err_bad_size  (err_bad_size)
  );

  task automatic idle_inputs();
    set_en = 1'b0; set_addr = '0; set_size = 2'd0;
    salu_clr_en = 1'b0; salu_clr_addr = '0; salu_clr_size = 2'd0;
    lsu_clr_en = 1'b0; lsu_clr_addr = '0; lsu_clr_size = 2'd0;
    flush_req = 1'b0; flush_base = '0; flush_count = '0;
  endtask

  // Advance one edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL reset_table got=%h exp=0", busy_table); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy got=%b exp=0", flush_busy); end
    checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL reset_flush_ack got=%b exp=0", flush_ack); end
    checks++; if ({err_double_set, err_clr_idle, err_bad_size} !== 3'b000) begin
      errors++; $display("FAIL reset_errs got=%b exp=000", {err_double_set, err_clr_idle, err_bad_size});
    end
  endtask

  task automatic test_set_basic();
    logic [N-1:0] exp;
    exp = '0; exp[13:10] = 4'hF;
    set_en = 1'b1; set_addr = 9'd10; set_size = 2'd2;
    step();
    idle_inputs();
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL set_basic_table got=%h exp=%h", busy_table, exp); end
    checks++; if ({err_double_set, err_clr_idle, err_bad_size} !== 3'b000) begin
      errors++; $display("FAIL set_basic_errs got=%b exp=000", {err_double_set, err_clr_idle, err_bad_size});
    end
    salu_clr_en = 1'b1; salu_clr_addr = 9'd10; salu_clr_size = 2'd2;
    step();
    idle_inputs();
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL set_basic_clear got=%h exp=0", busy_table); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp;
    exp = '0; exp[511] = 1'b1; exp[0] = 1'b1;
    set_en = 1'b1; set_addr = 9'd511; set_size = 2'd1;
    step();
    idle_inputs();
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL wrap_set got=%h exp=%h", busy_table, exp); end
    salu_clr_en = 1'b1; salu_clr_addr = 9'd511; salu_clr_size = 2'd1;
    step();
    idle_inputs();
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL wrap_clear got=%h exp=0", busy_table); end
    checks++; if (err_clr_idle !== 1'b0) begin errors++; $display("FAIL wrap_clr_idle got=%b exp=0", err_clr_idle); end
  endtask

  task automatic test_same_cycle();
    logic [N-1:0] exp;
    exp = '0; exp[20] = 1'b1;
    set_en = 1'b1; set_addr = 9'd20; set_size = 2'd0;
    step();
    set_en = 1'b1; set_addr = 9'd20; set_size = 2'd0;
    lsu_clr_en = 1'b1; lsu_clr_addr = 9'd20; lsu_clr_size = 2'd0;
    step();
    idle_inputs();
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL same_cycle_set_wins got=%h exp=%h", busy_table, exp); end
    checks++; if (err_clr_idle !== 1'b0) begin errors++; $display("FAIL same_cycle_clr_idle got=%b exp=0", err_clr_idle); end
    checks++; if (err_double_set !== 1'b1) begin errors++; $display("FAIL same_cycle_double_set got=%b exp=1", err_double_set); end
    lsu_clr_en = 1'b1; lsu_clr_addr = 9'd20; lsu_clr_size = 2'd0;
    step();
    idle_inputs();
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL same_cycle_lsu_clear got=%h exp=0", busy_table); end
  endtask

  task automatic test_flush_partial();
    logic [N-1:0] exp;
    int busy_cycles;
    int acks;
    for (int i = 0; i < 128; i++) begin
      set_en = 1'b1; set_addr = AW'(4 * i); set_size = 2'd2;
      step();
    end
    idle_inputs();
    checks++; if (busy_table !== {N{1'b1}}) begin errors++; $display("FAIL flush_fill got=%h exp=all ones", busy_table); end
    exp = {N{1'b1}};
    for (int i = 0; i < 20; i++) exp[(508 + i) % N] = 1'b0;
    flush_req = 1'b1; flush_base = 9'd508; flush_count = 10'd20;
    step();
    idle_inputs();
    busy_cycles = 0; acks = 0;
    while (flush_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      step();
      if (flush_ack === 1'b1) acks++;
    end
    step();
    if (flush_ack === 1'b1) acks++;
    checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL flush_partial_cycles got=%0d exp=3", busy_cycles); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL flush_partial_ack got=%0d exp=1", acks); end
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL flush_partial_table got=%h exp=%h", busy_table, exp); end
    checks++; if (busy_table[16] !== 1'b1) begin errors++; $display("FAIL flush_partial_bit16 got=%b exp=1", busy_table[16]); end
  endtask

  task automatic test_flush_zero();
    flush_req = 1'b1; flush_base = 9'd77; flush_count = 10'd0;
    step();
    idle_inputs();
    checks++; if (flush_ack !== 1'b1) begin errors++; $display("FAIL flush_zero_ack got=%b exp=1", flush_ack); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL flush_zero_busy got=%b exp=0", flush_busy); end
    step();
    checks++; if ({flush_ack, flush_busy} !== 2'b00) begin
      errors++; $display("FAIL flush_zero_after got=%b exp=00", {flush_ack, flush_busy});
    end
  endtask

  task automatic test_flush_full();
    int busy_cycles;
    int acks;
    flush_req = 1'b1; flush_base = 9'd100; flush_count = 10'd512;
    step();
    idle_inputs();
    busy_cycles = 0; acks = 0;
    while (flush_busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      step();
      if (flush_ack === 1'b1) acks++;
    end
    step();
    if (flush_ack === 1'b1) acks++;
    checks++; if (busy_cycles !== 64) begin errors++; $display("FAIL flush_full_cycles got=%0d exp=64", busy_cycles); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL flush_full_ack got=%0d exp=1", acks); end
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL flush_full_table got=%h exp=0", busy_table); end
  endtask

  task automatic test_set_vs_flush();
    logic [N-1:0] exp;
    exp = '0; exp[3] = 1'b1;
    set_en = 1'b1; set_addr = 9'd0; set_size = 2'd2;
    step();
    set_en = 1'b1; set_addr = 9'd4; set_size = 2'd2;
    step();
    idle_inputs();
    flush_req = 1'b1; flush_base = 9'd0; flush_count = 10'd8;
    step();
    idle_inputs();
    set_en = 1'b1; set_addr = 9'd3; set_size = 2'd0;
    step();
    idle_inputs();
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL set_vs_flush_table got=%h exp=%h", busy_table, exp); end
    checks++; if ({flush_ack, flush_busy} !== 2'b10) begin
      errors++; $display("FAIL set_vs_flush_ack got=%b exp=10", {flush_ack, flush_busy});
    end
  endtask

  task automatic test_reset_mid_flush();
    int acks;
    set_en = 1'b1; set_addr = 9'd200; set_size = 2'd2;
    step();
    idle_inputs();
    flush_req = 1'b1; flush_base = 9'd0; flush_count = 10'd512;
    step();
    idle_inputs();
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy_table !== '0) begin errors++; $display("FAIL rst_mid_flush_table got=%h exp=0", busy_table); end
    checks++; if ({flush_busy, flush_ack} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_flush_ctrl got=%b exp=00", {flush_busy, flush_ack});
    end
    acks = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (flush_ack === 1'b1 || flush_busy === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_flush_no_ack got=%0d exp=0", acks); end
    checks++; if ({err_double_set, err_clr_idle, err_bad_size} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_flush_errs got=%b exp=000", {err_double_set, err_clr_idle, err_bad_size});
    end
  endtask

  task automatic test_bad_size();
    logic [N-1:0] exp;
    exp = '0; exp[41:40] = 2'b11;
    set_en = 1'b1; set_addr = 9'd40; set_size = 2'd1;
    step();
    idle_inputs();
    salu_clr_en = 1'b1; salu_clr_addr = 9'd40; salu_clr_size = 2'd3;
    step();
    idle_inputs();
    checks++; if (err_bad_size !== 1'b1) begin errors++; $display("FAIL bad_size_flag got=%b exp=1", err_bad_size); end
    checks++; if (busy_table !== exp) begin errors++; $display("FAIL bad_size_table got=%h exp=%h", busy_table, exp); end
    checks++; if (err_clr_idle !== 1'b0) begin errors++; $display("FAIL bad_size_clr_idle got=%b exp=0", err_clr_idle); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_set_basic();
    test_wrap();
    test_same_cycle();
    test_flush_partial();
    test_flush_zero();
    test_flush_full();
    test_set_vs_flush();
    test_reset_mid_flush();
    test_bad_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sgpr_busy_table
`default_nettype wire
